// File: rtl/sram_1rw1r_if.sv
// ---------------------------------------------------------------------------
// sram_1rw1r_if
//
// Purpose : Shared SRAM control bus between the testchip control logic
//           (master) and a 1rw + 1r SRAM responder (slave).
//
// Signals :
//   csb0    port 0 chip select, active-low
//   web0    port 0 write enable, active-low (0 = write, 1 = read)
//   wmask0  port 0 lane write mask, active-high
//   addr0   port 0 address
//   din0    port 0 write data
//   dout0   port 0 read data (responder -> control logic)
//   csb1    port 1 chip select, active-low (read-only port)
//   addr1   port 1 address
//   dout1   port 1 read data (responder -> control logic)
// ---------------------------------------------------------------------------
interface sram_1rw1r_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_WMASKS = 4
);
   logic                  csb0;
   logic                  web0;
   logic [NUM_WMASKS-1:0] wmask0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] dout0;
   logic                  csb1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] dout1;

   modport master (
      output csb0, web0, wmask0, addr0, din0, csb1, addr1,
      input  dout0, dout1
   );

   modport slave (
      input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
      output dout0, dout1
   );
endinterface

// File: rtl/sram_1rw1r_responder.sv
// ---------------------------------------------------------------------------
// sram_1rw1r_responder
//
// Purpose : Synthesizable stand-in for a dual-port (1rw + 1r) OpenRAM macro.
//           After reset a clear sequencer writes zero to every word; only
//           then are the ports serviced. Same-address port-0 write / port-1
//           read collisions are flagged and counted (port 1 sees old data).
//
// Ports   :
//   clk0             single rising-edge clock for both ports
//   reset_n          asynchronous active-low reset
//   bus              sram_1rw1r_if.slave (csb0/web0/wmask0/addr0/din0/dout0,
//                    csb1/addr1/dout1)
//   init_done        high once the clear sequence has finished
//   collision        one-cycle pulse on a same-address write/read collision
//   collision_count  saturating 16-bit collision count
//
// Option  : define SRAM_RSP_OUTREG_EN to add an output register stage on
//           dout0, dout1 and collision (2-cycle read latency; the collision
//           pulse and count update stay aligned with the dout1 update).
// ---------------------------------------------------------------------------
module sram_1rw1r_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_WMASKS = 4
) (
   input  logic        clk0,
   input  logic        reset_n,
   sram_1rw1r_if.slave bus,
   output logic        init_done,
   output logic        collision,
   output logic [15:0] collision_count
);

   localparam int DEPTH      = 1 << ADDR_WIDTH;
   localparam int LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   generate
      if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_mask
         $error("DATA_WIDTH must be divisible by NUM_WMASKS");
      end
   endgenerate

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0]   dout0_q, dout0_d;
   logic [DATA_WIDTH-1:0]   dout1_q, dout1_d;
   logic                    collision_q, collision_d;
   logic [15:0]             count_q, count_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    ready;
   logic                    port0_wr;
   logic                    port0_rd;
   logic                    port1_rd;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_waddr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic                    count_inc;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk0 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_INIT: begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            // The edge that clears the last word also leaves INIT.
            if (ptr_q == LAST_ADDR) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      ready     = (state_q == ST_READY);
      init_done = ready;
   end

   // ------------------------------------------------------------------
   // Port decode and memory write port
   // ------------------------------------------------------------------
   always_comb begin
      port0_wr  = ready && !bus.csb0 && !bus.web0;
      port0_rd  = ready && !bus.csb0 &&  bus.web0;
      port1_rd  = ready && !bus.csb1;

      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = '0;

      if (!ready) begin
         // Clear sequencer owns the write port; bus inputs are ignored.
         mem_we = 1'b1;
      end else if (port0_wr && (|bus.wmask0)) begin
         // Read-modify-write of the addressed word keeps unmasked lanes.
         mem_we    = 1'b1;
         mem_waddr = bus.addr0;
         mem_wdata = mem_q[bus.addr0];
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (bus.wmask0[i]) begin
               mem_wdata[i*LANE_WIDTH +: LANE_WIDTH] =
                  bus.din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read data, collision detect, collision counter
   // ------------------------------------------------------------------
   always_comb begin
      // Reads see the pre-edge array, so a same-address port-1 read
      // returns old data while the write lands on the same edge.
      dout0_d     = port0_rd ? mem_q[bus.addr0] : dout0_q;
      dout1_d     = port1_rd ? mem_q[bus.addr1] : dout1_q;
      collision_d = port0_wr && (|bus.wmask0) && port1_rd &&
                    (bus.addr0 == bus.addr1);
      count_d     = count_q;
      if (count_inc && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk0 or negedge reset_n) begin
      if (!reset_n) begin
         dout0_q     <= '0;
         dout1_q     <= '0;
         collision_q <= 1'b0;
         count_q     <= '0;
      end else begin
         dout0_q     <= dout0_d;
         dout1_q     <= dout1_d;
         collision_q <= collision_d;
         count_q     <= count_d;
      end
   end

   // NOTE: the array has no reset; the clear sequencer zeroes it after
   // every reset, which keeps it mappable onto plain RAM.
   always_ff @(posedge clk0) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign collision_count = count_q;

`ifdef SRAM_RSP_OUTREG_EN
   // ------------------------------------------------------------------
   // Optional output register stage
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] dout0_o_q, dout0_o_d;
   logic [DATA_WIDTH-1:0] dout1_o_q, dout1_o_d;
   logic                  collision_o_q, collision_o_d;

   always_comb begin
      dout0_o_d     = dout0_q;
      dout1_o_d     = dout1_q;
      collision_o_d = collision_q;
   end

   always_ff @(posedge clk0 or negedge reset_n) begin
      if (!reset_n) begin
         dout0_o_q     <= '0;
         dout1_o_q     <= '0;
         collision_o_q <= 1'b0;
      end else begin
         dout0_o_q     <= dout0_o_d;
         dout1_o_q     <= dout1_o_d;
         collision_o_q <= collision_o_d;
      end
   end

   // Counting the first-stage pulse updates the count on the same edge
   // that raises the delayed collision output.
   assign count_inc = collision_q;
   assign bus.dout0 = dout0_o_q;
   assign bus.dout1 = dout1_o_q;
   assign collision = collision_o_q;
`else
   assign count_inc = collision_d;
   assign bus.dout0 = dout0_q;
   assign bus.dout1 = dout1_q;
   assign collision = collision_q;
`endif

endmodule

// File: tb/tb_sram_1rw1r_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_1rw1r_responder
//
// Directed bench for sram_1rw1r_responder. Inputs change and outputs are
// sampled 1 ns after each rising edge. Honours SRAM_RSP_OUTREG_EN (read
// latency 2 instead of 1).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_1rw1r_responder;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int NM = 4;
`ifdef SRAM_RSP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk0 = 1'b0;
   logic        reset_n;
   logic        init_done;
   logic        collision;
   logic [15:0] collision_count;

   int errors = 0;
   int checks = 0;

   sram_1rw1r_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) bus ();

   sram_1rw1r_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) dut (
      .clk0            (clk0),
      .reset_n         (reset_n),
      .bus             (bus),
      .init_done       (init_done),
      .collision       (collision),
      .collision_count (collision_count)
   );

   always #5 clk0 = ~clk0;

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk0);
         #1;
      end
   endtask

   task automatic idle();
      bus.csb0   = 1'b1;
      bus.web0   = 1'b1;
      bus.wmask0 = '0;
      bus.addr0  = '0;
      bus.din0   = '0;
      bus.csb1   = 1'b1;
      bus.addr1  = '0;
   endtask

   task automatic write0(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [NM-1:0] m);
      bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = a; bus.din0 = d; bus.wmask0 = m;
      step(1);
      idle();
   endtask

   // Issue reads for one cycle, then wait until the data is visible.
   task automatic read_ports(input logic en0, input logic [AW-1:0] a0,
                             input logic en1, input logic [AW-1:0] a1);
      bus.csb0 = !en0; bus.web0 = 1'b1; bus.addr0 = a0;
      bus.csb1 = !en1; bus.addr1 = a1;
      step(1);
      idle();
      step(LAT - 1);
   endtask

   task automatic wait_init(input string name);
      int n = 0;
      while (!init_done && n < 300) begin
         step(1);
         n++;
      end
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("FAIL %s init_done timeout got=%b exp=1", name, init_done);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      reset_n = 1'b0;
      step(2);
      checks++;
      if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL reset dout0 got=%h exp=0", bus.dout0); end
      checks++;
      if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL reset dout1 got=%h exp=0", bus.dout1); end
      checks++;
      if (init_done !== 1'b0) begin errors++; $display("FAIL reset init_done got=%b exp=0", init_done); end
      checks++;
      if (collision !== 1'b0) begin errors++; $display("FAIL reset collision got=%b exp=0", collision); end
      checks++;
      if (collision_count !== 16'h0) begin errors++; $display("FAIL reset count got=%h exp=0", collision_count); end
   endtask

   task automatic test_init();
      int early = 0;
      reset_n = 1'b1;
      for (int i = 1; i <= 255; i++) begin
         step(1);
         if (init_done !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin errors++; $display("FAIL init_early init_done high on %0d of 255 edges exp=0", early); end
      step(1);
      checks++;
      if (init_done !== 1'b1) begin errors++; $display("FAIL init_edge256 init_done got=%b exp=1", init_done); end
      read_ports(1'b0, 8'h00, 1'b1, 8'hFF);
      checks++;
      if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL init_clear dout1 got=%h exp=0", bus.dout1); end
   endtask

   task automatic test_write_read();
      write0(8'h10, 32'hDEADBEEF, 4'hF);
      bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 8'h10;
      step(1);
      idle();
`ifdef SRAM_RSP_OUTREG_EN
      checks++;
      if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL wr_rd_stage1 dout0 got=%h exp=0", bus.dout0); end
      step(1);
`endif
      checks++;
      if (bus.dout0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd dout0 got=%h exp=deadbeef", bus.dout0); end
      step(3);
      checks++;
      if (bus.dout0 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_hold dout0 got=%h exp=deadbeef", bus.dout0); end
   endtask

   task automatic test_wmask();
      write0(8'h20, 32'h11223344, 4'hF);
      write0(8'h20, 32'hAABBCCDD, 4'b0101);
      read_ports(1'b1, 8'h20, 1'b1, 8'h20);
      checks++;
      if (bus.dout1 !== 32'h11BB33DD) begin errors++; $display("FAIL wmask dout1 got=%h exp=11bb33dd", bus.dout1); end
      checks++;
      if (bus.dout0 !== 32'h11BB33DD) begin errors++; $display("FAIL dual_read dout0 got=%h exp=11bb33dd", bus.dout0); end
      checks++;
      if (collision_count !== 16'h0) begin errors++; $display("FAIL dual_read count got=%h exp=0", collision_count); end
   endtask

   task automatic test_collision();
      bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = 8'h30; bus.din0 = 32'h5; bus.wmask0 = 4'hF;
      bus.csb1 = 1'b0; bus.addr1 = 8'h30;
      step(1);
      idle();
      step(LAT - 1);
      checks++;
      if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL coll_old dout1 got=%h exp=0", bus.dout1); end
      checks++;
      if (collision !== 1'b1) begin errors++; $display("FAIL coll_pulse collision got=%b exp=1", collision); end
      checks++;
      if (collision_count !== 16'd1) begin errors++; $display("FAIL coll_count got=%h exp=1", collision_count); end
      step(1);
      checks++;
      if (collision !== 1'b0) begin errors++; $display("FAIL coll_one_cycle collision got=%b exp=0", collision); end
      read_ports(1'b0, 8'h00, 1'b1, 8'h30);
      checks++;
      if (bus.dout1 !== 32'h5) begin errors++; $display("FAIL coll_new dout1 got=%h exp=5", bus.dout1); end
   endtask

   task automatic test_zero_mask();
      bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = 8'h30; bus.din0 = 32'h77; bus.wmask0 = 4'h0;
      bus.csb1 = 1'b0; bus.addr1 = 8'h30;
      step(1);
      idle();
      step(LAT - 1);
      checks++;
      if (collision !== 1'b0) begin errors++; $display("FAIL zmask collision got=%b exp=0", collision); end
      checks++;
      if (collision_count !== 16'd1) begin errors++; $display("FAIL zmask count got=%h exp=1", collision_count); end
      read_ports(1'b1, 8'h30, 1'b0, 8'h00);
      checks++;
      if (bus.dout0 !== 32'h5) begin errors++; $display("FAIL zmask mem dout0 got=%h exp=5", bus.dout0); end
   endtask

   task automatic test_mid_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL mrst dout0 got=%h exp=0", bus.dout0); end
      checks++;
      if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL mrst dout1 got=%h exp=0", bus.dout1); end
      checks++;
      if (collision_count !== 16'h0) begin errors++; $display("FAIL mrst count got=%h exp=0", collision_count); end
      checks++;
      if (init_done !== 1'b0) begin errors++; $display("FAIL mrst init_done got=%b exp=0", init_done); end
      step(1);
      reset_n = 1'b1;
      // Bus activity during INIT must be ignored.
      step(4);
      bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = 8'h00; bus.din0 = 32'hFFFFFFFF; bus.wmask0 = 4'hF;
      step(1);
      bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 8'h00;
      bus.csb1 = 1'b0; bus.addr1 = 8'h00;
      step(1);
      idle();
      step(1);
      checks++;
      if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL init_ignore dout0 got=%h exp=0", bus.dout0); end
      checks++;
      if (collision_count !== 16'h0) begin errors++; $display("FAIL init_ignore count got=%h exp=0", collision_count); end
      wait_init("reinit");
      write0(8'h11, 32'hABCD1234, 4'hF);
      read_ports(1'b1, 8'h11, 1'b1, 8'h11);
      checks++;
      if (bus.dout0 !== 32'hABCD1234) begin errors++; $display("FAIL reinit_wr dout0 got=%h exp=abcd1234", bus.dout0); end
      read_ports(1'b1, 8'h10, 1'b1, 8'h00);
      checks++;
      if (bus.dout0 !== 32'h0) begin errors++; $display("FAIL reinit_clear dout0 got=%h exp=0", bus.dout0); end
      checks++;
      if (bus.dout1 !== 32'h0) begin errors++; $display("FAIL reinit_ignored dout1 got=%h exp=0", bus.dout1); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_write_read();
      test_wmask();
      test_collision();
      test_zero_mask();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
